// File: rtl/program_loader.sv
// Boot/overlay loader: copies a block of disk words into the instruction/data RAM,
// one REQ/WRITE pair per word, with range checking and a per-word ack timeout.
module program_loader #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MEM_DEPTH = 600,
  parameter int unsigned DISK_AW   = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DISK_AW-1:0] src_base,
  input  logic [ADDR_W-1:0]  dst_base,
  input  logic [ADDR_W-1:0]  length,
  output logic               disk_req,
  output logic [DISK_AW-1:0] disk_addr,
  input  logic               disk_ack,
  input  logic [DATA_W-1:0]  disk_data,
  output logic [DATA_W-1:0]  mem_dado,
  output logic [ADDR_W-1:0]  mem_endereco,
  output logic               mem_write,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TLAST  = TCNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]   DEPTH  = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t              state;
  logic [DISK_AW-1:0]  src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [ADDR_W-1:0]   len_q;
  logic [ADDR_W-1:0]   idx;
  logic [TCNT_W-1:0]   tcnt;

  logic [ADDR_W:0]     end_addr;
  logic [ADDR_W-1:0]   idx_inc;

  // One extra bit so dst_base+length cannot wrap past the depth check.
  always_comb begin
    end_addr = {1'b0, dst_base} + {1'b0, length};
    idx_inc  = idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      idx          <= '0;
      tcnt         <= '0;
      disk_req     <= 1'b0;
      disk_addr    <= '0;
      mem_dado     <= '0;
      mem_endereco <= '0;
      mem_write    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      done      <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_base;
            dst_q <= dst_base;
            len_q <= length;
            idx   <= '0;
            tcnt  <= '0;
            error <= 1'b0;
            busy  <= 1'b1;
            if (length == '0) begin
              state <= DONE;
            end else if (end_addr > DEPTH) begin
              state <= ERR;
            end else begin
              state     <= REQ;
              disk_req  <= 1'b1;
              disk_addr <= src_base;
            end
          end
        end
        REQ: begin
          if (disk_ack) begin
            mem_dado     <= disk_data;
            mem_endereco <= dst_q + idx;
            disk_req     <= 1'b0;
            mem_write    <= 1'b1;
            state        <= WRITE;
          end else if (tcnt == TLAST) begin
            disk_req <= 1'b0;
            state    <= ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WRITE: begin
          // mem_write was raised on entry; the RAM captures on this edge.
          idx  <= idx_inc;
          tcnt <= '0;
          if (idx_inc == len_q) begin
            state <= DONE;
          end else begin
            state     <= REQ;
            disk_req  <= 1'b1;
            disk_addr <= src_q + DISK_AW'(idx_inc);
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          error <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: behavioural RAM and a disk responder with
// configurable ack delay; each scenario task checks its own expectations.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] src_base;
  logic [9:0]  dst_base;
  logic [9:0]  length;
  logic        disk_req;
  logic [15:0] disk_addr;
  logic        disk_ack;
  logic [31:0] disk_data;
  logic [31:0] mem_dado;
  logic [9:0]  mem_endereco;
  logic        mem_write;
  logic        busy;
  logic        done;
  logic        error;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] ram [0:1023];
  int unsigned wr_count  = 0;
  int unsigned req_count = 0;
  logic [15:0] addr_log [$];
  int          ack_delay  = 0;
  bit          ack_enable = 1'b1;

  always #5 clk = ~clk;

  program_loader #(
    .DATA_W(32),
    .ADDR_W(10),
    .MEM_DEPTH(600),
    .DISK_AW(16),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .src_base(src_base),
    .dst_base(dst_base),
    .length(length),
    .disk_req(disk_req),
    .disk_addr(disk_addr),
    .disk_ack(disk_ack),
    .disk_data(disk_data),
    .mem_dado(mem_dado),
    .mem_endereco(mem_endereco),
    .mem_write(mem_write),
    .busy(busy),
    .done(done),
    .error(error)
  );

  // RAM: sentinel fill, then capture on posedge while mem_write is high.
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'hDEAD_0000 | 32'(i);
    forever begin
      @(posedge clk);
      if (mem_write === 1'b1) ram[mem_endereco] = mem_dado;
    end
  end

  // Disk responder and activity counters; data word = address - 90.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    disk_ack  = 1'b0;
    disk_data = '0;
    forever begin
      @(negedge clk);
      if (mem_write === 1'b1) wr_count++;
      if (disk_req === 1'b1) begin
        req_count++;
        if (ack_enable && wait_cnt >= ack_delay) begin
          addr_log.push_back(disk_addr);
          disk_ack  = 1'b1;
          disk_data = 32'(disk_addr) - 32'd90;
        end else begin
          disk_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        disk_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] s, input logic [9:0] d, input logic [9:0] l);
    src_base = s;
    dst_base = d;
    length   = l;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; length = '0;
    tick(); tick();
    checks++;
    if ({disk_req, busy, mem_write, done, error, disk_addr, mem_dado, mem_endereco} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0",
               {disk_req, busy, mem_write, done, error, disk_addr, mem_dado, mem_endereco});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b required 0", busy); end
  endtask

  task automatic test_single_copy();
    int unsigned w0;
    int cyc;
    ack_delay = 0; ack_enable = 1'b1;
    w0 = wr_count;
    pulse_start(16'd100, 10'd0, 10'd3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b required 1", busy); end
    checks++;
    if (disk_req !== 1'b1 || disk_addr !== 16'd100) begin
      errors++; $display("FAIL t1_first_req got req=%b addr=%0d required req=1 addr=100", disk_req, disk_addr);
    end
    wait_done(40, cyc);
    checks++;
    if (cyc !== 7) begin errors++; $display("FAIL t1_done_cycle got %0d required 7", cyc); end
    checks++;
    if (error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL t1_flags got error=%b busy=%b required 0 0", error, busy);
    end
    checks++;
    if (wr_count - w0 !== 3) begin errors++; $display("FAIL t1_write_pulses got %0d required 3", wr_count - w0); end
    checks++;
    if (ram[0] !== 32'hA || ram[1] !== 32'hB || ram[2] !== 32'hC) begin
      errors++; $display("FAIL t1_ram got %h %h %h required a b c", ram[0], ram[1], ram[2]);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL t1_done_width got %b required 0", done); end
    checks++;
    if (mem_endereco !== 10'd2 || mem_dado !== 32'hC) begin
      errors++; $display("FAIL t1_hold got addr=%0d data=%h required 2 c", mem_endereco, mem_dado);
    end
  endtask

  task automatic test_range_error();
    int unsigned w0, r0;
    w0 = wr_count; r0 = req_count;
    pulse_start(16'd200, 10'd598, 10'd3);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || disk_req !== 1'b0) begin
      errors++; $display("FAIL t2_accept got busy=%b done=%b req=%b required 1 0 0", busy, done, disk_req);
    end
    tick();
    checks++;
    if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL t2_err got done=%b error=%b busy=%b required 1 1 0", done, error, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || error !== 1'b1) begin
      errors++; $display("FAIL t2_sticky got done=%b error=%b required 0 1", done, error);
    end
    checks++;
    if (req_count - r0 !== 0 || wr_count - w0 !== 0) begin
      errors++; $display("FAIL t2_no_activity got req=%0d wr=%0d required 0 0", req_count - r0, wr_count - w0);
    end
  endtask

  task automatic test_zero_length();
    int unsigned w0, r0;
    w0 = wr_count; r0 = req_count;
    pulse_start(16'd150, 10'd5, 10'd0);
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL t3_error_cleared got %b required 0", error); end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL t3_done got done=%b busy=%b required 1 0", done, busy);
    end
    checks++;
    if (req_count - r0 !== 0 || wr_count - w0 !== 0) begin
      errors++; $display("FAIL t3_no_activity got req=%0d wr=%0d required 0 0", req_count - r0, wr_count - w0);
    end
  endtask

  task automatic test_timeout();
    int unsigned w0, r0;
    int cyc;
    ack_enable = 1'b0;
    w0 = wr_count; r0 = req_count;
    pulse_start(16'd300, 10'd10, 10'd2);
    wait_done(400, cyc);
    checks++;
    if (cyc !== 256) begin errors++; $display("FAIL t4_done_cycle got %0d required 256", cyc); end
    checks++;
    if (req_count - r0 !== 255) begin errors++; $display("FAIL t4_req_cycles got %0d required 255", req_count - r0); end
    checks++;
    if (error !== 1'b1 || disk_req !== 1'b0 || wr_count - w0 !== 0) begin
      errors++; $display("FAIL t4_flags got error=%b req=%b wr=%0d required 1 0 0", error, disk_req, wr_count - w0);
    end
    ack_enable = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_copy();
    int unsigned w0;
    int cyc;
    w0 = wr_count;
    pulse_start(16'd400, 10'd20, 10'd5);
    repeat (4) tick();
    checks++;
    if (wr_count - w0 !== 2) begin errors++; $display("FAIL t5_writes_before got %0d required 2", wr_count - w0); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({disk_req, busy, mem_write, done, error, disk_addr, mem_dado, mem_endereco} !== '0) begin
      errors++; $display("FAIL t5_async_reset got %h required 0",
                         {disk_req, busy, mem_write, done, error, disk_addr, mem_dado, mem_endereco});
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (ram[20] !== 32'd310 || ram[21] !== 32'd311) begin
      errors++; $display("FAIL t5_partial got %h %h required 136 137", ram[20], ram[21]);
    end
    checks++;
    if (ram[22] !== 32'hDEAD_0016 || ram[23] !== 32'hDEAD_0017) begin
      errors++; $display("FAIL t5_untouched got %h %h required dead0016 dead0017", ram[22], ram[23]);
    end
    pulse_start(16'd400, 10'd20, 10'd5);
    wait_done(60, cyc);
    checks++;
    if (cyc !== 11) begin errors++; $display("FAIL t5_restart_cycle got %0d required 11", cyc); end
    checks++;
    if (ram[22] !== 32'd312 || ram[24] !== 32'd314 || error !== 1'b0) begin
      errors++; $display("FAIL t5_restart got %h %h err=%b required 138 13a 0", ram[22], ram[24], error);
    end
  endtask

  task automatic test_busy_start_and_boundary();
    int unsigned w0, q0;
    int cyc;
    ack_delay = 4;
    w0 = wr_count; q0 = addr_log.size();
    pulse_start(16'd500, 10'd40, 10'd3);
    pulse_start(16'd9, 10'd100, 10'd1);
    wait_done(60, cyc);
    checks++;
    if (cyc !== 18) begin errors++; $display("FAIL t6_done_cycle got %0d required 18", cyc); end
    checks++;
    if (addr_log.size() - q0 !== 3) begin
      errors++; $display("FAIL t6_req_count got %0d required 3", addr_log.size() - q0);
    end
    for (int k = 0; k < 3; k++) begin
      if (q0 + k < addr_log.size()) begin
        checks++;
        if (addr_log[q0 + k] !== 16'(500 + k)) begin
          errors++; $display("FAIL t6_disk_addr%0d got %0d required %0d", k, addr_log[q0 + k], 500 + k);
        end
      end
    end
    checks++;
    if (ram[40] !== 32'd410 || ram[42] !== 32'd412 || ram[100] !== 32'hDEAD_0064) begin
      errors++; $display("FAIL t6_ram got %h %h %h required 19a 19c dead0064", ram[40], ram[42], ram[100]);
    end
    checks++;
    if (wr_count - w0 !== 3 || error !== 1'b0) begin
      errors++; $display("FAIL t6_writes got %0d err=%b required 3 0", wr_count - w0, error);
    end
    ack_delay = 0;
    tick();
    pulse_start(16'd50, 10'd599, 10'd1);
    wait_done(20, cyc);
    checks++;
    if (cyc !== 3 || error !== 1'b0) begin
      errors++; $display("FAIL t6_boundary got cyc=%0d err=%b required 3 0", cyc, error);
    end
    checks++;
    if (ram[599] !== 32'hFFFF_FFD8) begin
      errors++; $display("FAIL t6_ram599 got %h required ffffffd8", ram[599]);
    end
  endtask

  task automatic test_back_to_back_wrap();
    int unsigned q0;
    int cyc;
    q0 = addr_log.size();
    pulse_start(16'hFFFF, 10'd60, 10'd2);
    wait_done(30, cyc);
    checks++;
    if (cyc !== 5) begin errors++; $display("FAIL t7_done_cycle got %0d required 5", cyc); end
    checks++;
    if (addr_log.size() - q0 !== 2) begin
      errors++; $display("FAIL t7_req_count got %0d required 2", addr_log.size() - q0);
    end else if (addr_log[q0] !== 16'hFFFF || addr_log[q0 + 1] !== 16'h0000) begin
      errors++; $display("FAIL t7_wrap got %h %h required ffff 0000", addr_log[q0], addr_log[q0 + 1]);
    end
    checks++;
    if (ram[60] !== 32'h0000_FFA5 || ram[61] !== 32'hFFFF_FFA6) begin
      errors++; $display("FAIL t7_ram got %h %h required 0000ffa5 ffffffa6", ram[60], ram[61]);
    end
  endtask

  initial begin
    test_reset();
    test_single_copy();
    test_range_error();
    test_zero_length();
    test_timeout();
    test_reset_mid_copy();
    test_busy_start_and_boundary();
    test_back_to_back_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
